// File: rtl/id_stage_sb_if.sv
// ID-stage signal bundle: IF/ID inputs, write-back port, downstream control and ID/EX outputs.
// master drives the ID/WB/control side; slave is the decode stage itself.
interface id_stage_sb_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32
);
   localparam int unsigned AW = $clog2(NREG);

   logic            valid_id;
   logic [31:0]     Instruction_id;
   logic [XLEN-1:0] PC_id;
   logic            RegWrite_wb;
   logic [AW-1:0]   rdAddr_wb;
   logic [XLEN-1:0] RegWriteData_wb;
   logic            flush;
   logic            hold_ex;
   logic            Stall;
   logic            IFWrite;
   logic            valid_ex;
   logic [31:0]     Instruction_ex;
   logic [XLEN-1:0] PC_ex;
   logic [XLEN-1:0] rs1Data_ex;
   logic [XLEN-1:0] rs2Data_ex;
   logic [AW-1:0]   rs1Addr_ex;
   logic [AW-1:0]   rs2Addr_ex;
   logic [AW-1:0]   rdAddr_ex;
   logic            MemRead_ex;

   modport master (
      output valid_id, Instruction_id, PC_id, RegWrite_wb, rdAddr_wb, RegWriteData_wb,
             flush, hold_ex,
      input  Stall, IFWrite, valid_ex, Instruction_ex, PC_ex, rs1Data_ex, rs2Data_ex,
             rs1Addr_ex, rs2Addr_ex, rdAddr_ex, MemRead_ex
   );

   modport slave (
      input  valid_id, Instruction_id, PC_id, RegWrite_wb, rdAddr_wb, RegWriteData_wb,
             flush, hold_ex,
      output Stall, IFWrite, valid_ex, Instruction_ex, PC_ex, rs1Data_ex, rs2Data_ex,
             rs1Addr_ex, rs2Addr_ex, rdAddr_ex, MemRead_ex
   );
endinterface

// File: rtl/id_stage_sb.sv
// Decode stage: register file with write-back bypass, per-register load scoreboard for
// load-use stalls, and the ID/EX pipeline register with bubble insertion and hold.
module id_stage_sb #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREG     = 32,
   parameter int unsigned LOAD_LAT = 1
) (
   input logic          clk,
   input logic          rst_n,
   id_stage_sb_if.slave bus
);
   localparam int unsigned AW = $clog2(NREG);
   localparam int unsigned CW = $clog2(LOAD_LAT + 1);
   localparam logic [CW-1:0] LatCnt = CW'(LOAD_LAT);

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;

   typedef struct packed {
      logic            valid;
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [AW-1:0]   rs1;
      logic [AW-1:0]   rs2;
      logic [AW-1:0]   rd;
      logic            mem_read;
   } ex_t;

   logic [6:0]      opcode;
   logic [AW-1:0]   rs1, rs2, rd;
   logic            uses_rs1, uses_rs2, is_load;
   logic            hazard, stall, issue;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic [XLEN-1:0] rf_q [NREG];
   logic [CW-1:0]   pend_q [NREG];
   logic [CW-1:0]   pend_d [NREG];
   ex_t             ex_q, ex_d;

   assign opcode   = bus.Instruction_id[6:0];
   assign rs1      = bus.Instruction_id[15 +: AW];
   assign rs2      = bus.Instruction_id[20 +: AW];
   assign rd       = bus.Instruction_id[7 +: AW];
   assign uses_rs1 = !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
   assign uses_rs2 = (opcode == OpReg) || (opcode == OpStore) || (opcode == OpBranch);
   assign is_load  = (opcode == OpLoad);

   // Write-through lets a same-cycle WB value reach the operand captured into EX.
   function automatic logic [XLEN-1:0] read_reg(input logic [AW-1:0] addr);
      if (addr == '0) return '0;
      if (bus.RegWrite_wb && bus.rdAddr_wb == addr) return bus.RegWriteData_wb;
      return rf_q[addr];
   endfunction

   assign rs1_data = read_reg(rs1);
   assign rs2_data = read_reg(rs2);

   assign hazard = (uses_rs1 && rs1 != '0 && pend_q[rs1] != '0) ||
                   (uses_rs2 && rs2 != '0 && pend_q[rs2] != '0);
   assign stall  = bus.valid_id && !bus.flush && hazard;
   assign issue  = bus.valid_id && !bus.flush && !stall && !bus.hold_ex;

   assign bus.Stall   = stall;
   assign bus.IFWrite = !stall && !bus.hold_ex;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (bus.RegWrite_wb && bus.rdAddr_wb != '0) begin
         rf_q[bus.rdAddr_wb] <= bus.RegWriteData_wb;
      end
   end

   // A load issuing this cycle reloads its counter, overriding the per-cycle decrement.
   always_comb begin
      for (int unsigned r = 0; r < NREG; r++) begin
         pend_d[r] = pend_q[r];
         if (!bus.hold_ex && pend_q[r] != '0) pend_d[r] = pend_q[r] - 1'b1;
         if (issue && is_load && rd != '0 && AW'(r) == rd) pend_d[r] = LatCnt;
      end
      pend_d[0] = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) pend_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NREG; i++) pend_q[i] <= pend_d[i];
      end
   end

   always_comb begin
      ex_d = ex_q;
      if (!bus.hold_ex) begin
         ex_d = '0;
         if (issue) begin
            ex_d.valid    = 1'b1;
            ex_d.instr    = bus.Instruction_id;
            ex_d.pc       = bus.PC_id;
            ex_d.rs1_data = rs1_data;
            ex_d.rs2_data = rs2_data;
            ex_d.rs1      = rs1;
            ex_d.rs2      = rs2;
            ex_d.rd       = rd;
            ex_d.mem_read = is_load;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   assign bus.valid_ex       = ex_q.valid;
   assign bus.Instruction_ex = ex_q.instr;
   assign bus.PC_ex          = ex_q.pc;
   assign bus.rs1Data_ex     = ex_q.rs1_data;
   assign bus.rs2Data_ex     = ex_q.rs2_data;
   assign bus.rs1Addr_ex     = ex_q.rs1;
   assign bus.rs2Addr_ex     = ex_q.rs2;
   assign bus.rdAddr_ex      = ex_q.rd;
   assign bus.MemRead_ex     = ex_q.mem_read;
endmodule

// File: tb/tb_id_stage_sb.sv
// Randomized bench for id_stage_sb: timestamp-based availability model feeds an issue
// queue that a monitor drains against the ID/EX outputs; Stall/IFWrite checked each cycle.
module tb_id_stage_sb;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned NREG     = 32;
   localparam int unsigned LOAD_LAT = 3;
   localparam int unsigned AW       = $clog2(NREG);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_ADD  = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_AUI  = 7'b0010111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   typedef struct packed {
      logic            v;
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] d1;
      logic [XLEN-1:0] d2;
      logic [AW-1:0]   a1;
      logic [AW-1:0]   a2;
      logic [AW-1:0]   rd;
      logic            mr;
   } ex_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   id_stage_sb_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

   id_stage_sb #(.XLEN(XLEN), .NREG(NREG), .LOAD_LAT(LOAD_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;
   ex_t exp_q[$];

   // Model: a register is busy until the unheld-cycle tick reaches its availability stamp.
   logic [XLEN-1:0] m_regs [NREG];
   longint m_avail [NREG];
   longint m_tick;
   logic   stall_exp, last_keep, dut_stall;
   logic   hold_prev = 1'b0;
   logic [XLEN-1:0] pc_ctr = 32'h1000;

   always @(posedge clk) hold_prev <= bus.hold_ex;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_ex(input string name, input ex_t act, input ex_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic uses1(input logic [6:0] op);
      return !(op == OP_LUI || op == OP_AUI || op == OP_JAL);
   endfunction

   function automatic logic uses2(input logic [6:0] op);
      return op == OP_ADD || op == OP_SW || op == OP_BEQ;
   endfunction

   function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (bus.RegWrite_wb && bus.rdAddr_wb == a) return bus.RegWriteData_wb;
      return m_regs[a];
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int r1,
                                      input int r2);
      return {7'd0, 5'(r2), 5'(r1), 3'd0, 5'(rd), op};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0] op;
      case ($urandom_range(0, 9))
         0, 1, 2: op = OP_LW;
         3, 4:    op = OP_ADD;
         5:       op = OP_ADDI;
         6:       op = OP_LUI;
         7:       op = OP_JAL;
         8:       op = OP_SW;
         default: op = OP_BEQ;
      endcase
      return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              3'($urandom), 5'($urandom_range(0, 7)), op};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_regs[i] = '0;
         m_avail[i] = 0;
      end
      m_tick = 0;
      last_keep = 1'b0;
      exp_q.delete();
   endtask

   // Evaluate the current cycle's inputs against the model, then advance it past the edge.
   task automatic eval_cycle();
      logic [31:0] ins;
      logic [AW-1:0] a1, a2, rd;
      logic h1, h2, issue;
      ex_t e;
      ins = bus.Instruction_id;
      a1 = ins[15 +: AW];
      a2 = ins[20 +: AW];
      rd = ins[7 +: AW];
      h1 = uses1(ins[6:0]) && a1 != 0 && m_tick < m_avail[a1];
      h2 = uses2(ins[6:0]) && a2 != 0 && m_tick < m_avail[a2];
      stall_exp = bus.valid_id && !bus.flush && (h1 || h2);
      dut_stall = bus.Stall;
      chk("stall", 64'(bus.Stall), 64'(stall_exp));
      chk("ifwrite", 64'(bus.IFWrite), 64'(!stall_exp && !bus.hold_ex));
      issue = bus.valid_id && !bus.flush && !stall_exp && !bus.hold_ex;
      last_keep = bus.valid_id && !bus.flush && (stall_exp || bus.hold_ex);
      if (issue) begin
         e.v = 1'b1; e.instr = ins; e.pc = bus.PC_id; e.d1 = m_read(a1); e.d2 = m_read(a2);
         e.a1 = a1; e.a2 = a2; e.rd = rd; e.mr = (ins[6:0] == OP_LW);
         exp_q.push_back(e);
         if (ins[6:0] == OP_LW && rd != 0) m_avail[rd] = m_tick + 1 + LOAD_LAT;
      end
      if (!bus.hold_ex) m_tick++;
      if (bus.RegWrite_wb && bus.rdAddr_wb != 0) m_regs[bus.rdAddr_wb] = bus.RegWriteData_wb;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                        input logic fl, input logic hd, input logic we,
                        input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
      bus.valid_id = v; bus.Instruction_id = ins; bus.PC_id = pc;
      bus.flush = fl; bus.hold_ex = hd;
      bus.RegWrite_wb = we; bus.rdAddr_wb = wa; bus.RegWriteData_wb = wd;
   endtask

   task automatic step();
      @(negedge clk);
      eval_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
         step();
      end
   endtask

   // Present one instruction until it leaves ID; count unheld stall cycles reported by the DUT.
   task automatic run_instr(input logic [31:0] ins, input logic fl, input int hd,
                            output int stalls);
      int n;
      n = 0;
      stalls = 0;
      pc_ctr += 4;
      forever begin
         drive(1'b1, ins, pc_ctr, fl, n < hd, 1'b0, '0, '0);
         step();
         if (dut_stall && !(n < hd)) stalls++;
         n++;
         if (!last_keep) break;
         if (n > 30) begin
            checks++; failures++;
            $display("FAIL run_instr_timeout: got %0d cycles required at most 30", n);
            break;
         end
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_valid_ex"}, 64'(bus.valid_ex), 0);
      chk({tag, "_instr_ex"}, 64'(bus.Instruction_ex), 0);
      chk({tag, "_pc_ex"}, 64'(bus.PC_ex), 0);
      chk({tag, "_rs1data"}, 64'(bus.rs1Data_ex), 0);
      chk({tag, "_rs2data"}, 64'(bus.rs2Data_ex), 0);
      chk({tag, "_rd_ex"}, 64'(bus.rdAddr_ex), 0);
      chk({tag, "_memread"}, 64'(bus.MemRead_ex), 0);
      chk({tag, "_stall"}, 64'(bus.Stall), 0);
      chk({tag, "_ifwrite"}, 64'(bus.IFWrite), 1);
   endtask

   task automatic reset_mid();
      bus.hold_ex = 1'b0;
      bus.RegWrite_wb = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_state("midreset");
      model_reset();
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pc_ctr += 4;
      drive(1'b1, mk(OP_ADD, 3, 1, 2), pc_ctr, 1'b0, 1'b0, 1'b0, '0, '0);
      step();
      chk("post_reset_issue_valid", 64'(bus.valid_ex), 1);
      chk("post_reset_issue_instr", 64'(bus.Instruction_ex), 64'(mk(OP_ADD, 3, 1, 2)));
   endtask

   initial begin : monitor
      ex_t act, last;
      last = '0;
      forever begin
         @(negedge clk);
         act.v = bus.valid_ex; act.instr = bus.Instruction_ex; act.pc = bus.PC_ex;
         act.d1 = bus.rs1Data_ex; act.d2 = bus.rs2Data_ex; act.a1 = bus.rs1Addr_ex;
         act.a2 = bus.rs2Addr_ex; act.rd = bus.rdAddr_ex; act.mr = bus.MemRead_ex;
         if (!rst_n) begin
            last = '0;
         end else if (hold_prev) begin
            chk_ex("ex_hold_stable", act, last);
         end else if (act.v) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL ex_unexpected_issue: got %h required no issue", act);
            end else begin
               last = exp_q.pop_front();
               chk_ex("ex_issue", act, last);
            end
         end else begin
            last = '0;
            chk_ex("ex_bubble", act, last);
         end
      end
   end

   initial begin : stim
      int s;
      logic [31:0] cur;
      logic cv;
      model_reset();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      #22;
      check_reset_state("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Write-through: WB of x9 in the cycle ADD x1,x9,x9 issues.
      pc_ctr += 4;
      drive(1'b1, mk(OP_ADD, 1, 9, 9), pc_ctr, 1'b0, 1'b0, 1'b1, AW'(9), 32'hDEADBEEF);
      step();
      chk("wt_rs1", 64'(bus.rs1Data_ex), 64'h0000_0000_DEAD_BEEF);
      chk("wt_rs2", 64'(bus.rs2Data_ex), 64'h0000_0000_DEAD_BEEF);

      // Load-use directly behind.
      run_instr(mk(OP_LW, 5, 1, 0), 1'b0, 0, s);
      run_instr(mk(OP_ADD, 6, 5, 1), 1'b0, 0, s);
      chk("loaduse_stalls", 64'(s), 64'(LOAD_LAT));
      // Reload of a still-pending register restarts the wait.
      run_instr(mk(OP_LW, 5, 1, 0), 1'b0, 0, s);
      run_instr(mk(OP_LW, 5, 2, 0), 1'b0, 0, s);
      run_instr(mk(OP_ADD, 6, 1, 5), 1'b0, 0, s);
      chk("reload_stalls", 64'(s), 64'(LOAD_LAT));

      // No false hazards.
      run_instr(mk(OP_LW, 0, 1, 0), 1'b0, 0, s);
      run_instr(mk(OP_ADD, 1, 0, 0), 1'b0, 0, s);
      chk("x0_nostall", 64'(s), 0);
      idle(LOAD_LAT);
      run_instr(mk(OP_LW, 5, 1, 0), 1'b0, 0, s);
      run_instr(mk(OP_LUI, 5, 5, 5), 1'b0, 0, s);
      chk("lui_nostall", 64'(s), 0);
      run_instr(mk(OP_JAL, 1, 5, 5), 1'b0, 0, s);
      chk("jal_nostall", 64'(s), 0);
      idle(LOAD_LAT);
      run_instr(mk(OP_LW, 5, 1, 0), 1'b0, 0, s);
      run_instr(mk(OP_ADDI, 7, 6, 5), 1'b0, 0, s);
      chk("addi_nostall", 64'(s), 0);
      idle(LOAD_LAT);

      // Flush beats stall; flushed load leaves no pending state.
      run_instr(mk(OP_LW, 5, 1, 0), 1'b0, 0, s);
      run_instr(mk(OP_ADD, 6, 5, 1), 1'b1, 0, s);
      chk("flush_nostall", 64'(s), 0);
      idle(LOAD_LAT);
      run_instr(mk(OP_LW, 7, 1, 0), 1'b1, 0, s);
      run_instr(mk(OP_ADD, 1, 7, 7), 1'b0, 0, s);
      chk("flushed_load_nostall", 64'(s), 0);

      // hold_ex freezes the scoreboard.
      idle(LOAD_LAT);
      run_instr(mk(OP_LW, 5, 1, 0), 1'b0, 0, s);
      run_instr(mk(OP_ADD, 6, 5, 1), 1'b0, 3, s);
      chk("hold_then_stalls", 64'(s), 64'(LOAD_LAT));

      // Randomized traffic with a mid-stream reset.
      cur = '0;
      cv = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if (!last_keep) begin
            cv = ($urandom_range(0, 9) != 0);
            cur = rand_instr();
            pc_ctr += 4;
         end
         drive(cv, cur, pc_ctr, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
               1'($urandom), AW'($urandom_range(0, 7)), $urandom);
         step();
         if (i == 400) reset_mid();
      end

      idle(3);
      chk("queue_drained", 64'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
